// File: rtl/cache_axi_pkg.sv
// Shared definitions for the cache read arbiter.
//  - state_e    : one-hot FSM encoding (S_IDLE, S_AR, S_R, S_RESP)
//  - BURST_INCR : AXI INCR burst type
//  - SIZE_4B    : AXI 4-byte beat size
//  - REQ_I/REQ_D: requester index into the req/grant vectors
//  - LINE_WORDS : default beats per cache line
package cache_axi_pkg;

    localparam int LINE_WORDS = 8;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;

    localparam int REQ_I = 0;
    localparam int REQ_D = 1;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_AR   = 4'b0010,
        S_R    = 4'b0100,
        S_RESP = 4'b1000
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//  clk, reset : clock, synchronous active-high reset
//  req[1:0]   : requests, indexed by REQ_I / REQ_D
//  advance    : a grant was accepted this cycle; remember the winner
//  grant[1:0] : combinational one-hot (or zero) grant
// A lone requester always wins. On a tie, the requester that did not win
// most recently is granted. last_grant starts at REQ_I, so the first tie
// after reset goes to REQ_D.
module rr_arb2
    import cache_axi_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // 0 = icache won last, 1 = dcache won last
    logic last_grant_reg;

    always_comb begin
        grant = 2'b00;
        if (req[REQ_I] && req[REQ_D]) begin
            if (last_grant_reg == 1'(REQ_D)) begin
                grant[REQ_I] = 1'b1;
            end else begin
                grant[REQ_D] = 1'b1;
            end
        end else begin
            grant = req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_reg <= 1'(REQ_I);
        end else if (advance && (grant != 2'b00)) begin
            last_grant_reg <= grant[REQ_D];
        end
    end

endmodule

// File: rtl/cache_rd_arbiter.sv
// Shares one AXI read channel between the icache and dcache read ports.
// One transaction is outstanding at a time: an 8-beat INCR burst for a line
// refill or a single beat for an uncached read. Returned beats are packed
// into a line-wide word and handed back with a one-cycle ret_valid pulse.
// Ports:
//  clk, reset                 : clock, synchronous active-high reset
//  i_rd_* / d_rd_*            : request handshake from icache / dcache
//  i_ret_* / d_ret_*          : line return to icache / dcache
//  arid..arvalid, arready     : AXI AR channel
//  rdata, rlast, rvalid, rready : AXI R channel (rid/rresp not used)
module cache_rd_arbiter
    import cache_axi_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = cache_axi_pkg::LINE_WORDS,
    parameter int ID_I       = 0,
    parameter int ID_D       = 1
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         i_rd_req,
    input  logic                         i_rd_type,
    input  logic [ADDR_W-1:0]            i_rd_addr,
    output logic                         i_rd_rdy,
    output logic                         i_ret_valid,
    output logic [LINE_WORDS*DATA_W-1:0] i_ret_data,

    input  logic                         d_rd_req,
    input  logic                         d_rd_type,
    input  logic [ADDR_W-1:0]            d_rd_addr,
    output logic                         d_rd_rdy,
    output logic                         d_ret_valid,
    output logic [LINE_WORDS*DATA_W-1:0] d_ret_data,

    output logic [3:0]                   arid,
    output logic [ADDR_W-1:0]            araddr,
    output logic [7:0]                   arlen,
    output logic [2:0]                   arsize,
    output logic [1:0]                   arburst,
    output logic                         arvalid,
    input  logic                         arready,

    input  logic [DATA_W-1:0]            rdata,
    input  logic                         rlast,
    input  logic                         rvalid,
    output logic                         rready
);

    localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    state_e              state_reg, state_next;
    logic                owner_reg;      // 0 = icache, 1 = dcache
    logic                type_reg;       // 1 = line burst
    logic [ADDR_W-1:0]   addr_reg;
    logic [BEAT_W-1:0]   beat_cnt_reg;
    logic                full_reg;       // last buffer word already written

    logic [1:0]          req;
    logic [1:0]          grant;
    logic                accept;
    logic                beat_we;
    logic [LINE_WORDS*DATA_W-1:0] line_data;

    assign req = {d_rd_req, i_rd_req};

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (accept),
        .grant   (grant)
    );

    // Next state and handshake outputs. Everything is forced low while
    // reset is high, whatever state the register still holds.
    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        i_rd_rdy    = 1'b0;
        d_rd_rdy    = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        i_ret_valid = 1'b0;
        d_ret_valid = 1'b0;
        if (!reset) begin
            case (state_reg)
                S_IDLE: begin
                    i_rd_rdy = grant[REQ_I];
                    d_rd_rdy = grant[REQ_D];
                    accept   = (grant != 2'b00);
                    if (accept) state_next = S_AR;
                end
                S_AR: begin
                    arvalid = 1'b1;
                    if (arready) state_next = S_R;
                end
                S_R: begin
                    rready = 1'b1;
                    if (rvalid && rlast) state_next = S_RESP;
                end
                S_RESP: begin
                    i_ret_valid = ~owner_reg;
                    d_ret_valid = owner_reg;
                    state_next  = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Beats beyond the last buffer word are accepted but dropped.
    assign beat_we = rready && rvalid && !full_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_reg    <= 1'b0;
            type_reg     <= 1'b0;
            addr_reg     <= '0;
            beat_cnt_reg <= '0;
            full_reg     <= 1'b0;
        end else if (accept) begin
            owner_reg    <= grant[REQ_D];
            type_reg     <= grant[REQ_D] ? d_rd_type : i_rd_type;
            addr_reg     <= grant[REQ_D] ? d_rd_addr : i_rd_addr;
            beat_cnt_reg <= '0;
            full_reg     <= 1'b0;
        end else if (beat_we) begin
            if (beat_cnt_reg == BEAT_W'(LINE_WORDS - 1)) begin
                full_reg <= 1'b1;
            end else begin
                beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
        end
    end

    // Line buffer: cleared on accept so words a short burst never reaches
    // (and the upper words of an uncached read) return as zero.
    generate
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
            logic [DATA_W-1:0] word_reg;
            always_ff @(posedge clk) begin
                if (accept) begin
                    word_reg <= '0;
                end else if (beat_we && (beat_cnt_reg == BEAT_W'(gi))) begin
                    word_reg <= rdata;
                end
            end
            assign line_data[gi*DATA_W +: DATA_W] = word_reg;
        end
    endgenerate

    assign i_ret_data = line_data;
    assign d_ret_data = line_data;

    assign arid    = owner_reg ? 4'(ID_D) : 4'(ID_I);
    assign araddr  = addr_reg;
    assign arlen   = type_reg ? 8'(LINE_WORDS - 1) : 8'd0;
    assign arsize  = SIZE_4B;
    assign arburst = BURST_INCR;

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Self-checking bench for cache_rd_arbiter: directed scenarios followed by
// randomized traffic. The bench plays the AXI slave and predicts grants and
// returned lines from a simple transaction-level model.
module tb_cache_rd_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_rd_req, i_rd_type, d_rd_req, d_rd_type;
    logic [31:0]  i_rd_addr, d_rd_addr;
    logic         i_rd_rdy, i_ret_valid, d_rd_rdy, d_ret_valid;
    logic [255:0] i_ret_data, d_ret_data;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid, arready;
    logic [31:0]  rdata;
    logic         rlast, rvalid, rready;

    int n_cmp = 0;
    int n_bad = 0;
    int model_last = 0;   // requester granted most recently: 0 = I, 1 = D
    int txn_no = 0;

    always #5 clk = ~clk;

    cache_rd_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .i_rd_req    (i_rd_req),
        .i_rd_type   (i_rd_type),
        .i_rd_addr   (i_rd_addr),
        .i_rd_rdy    (i_rd_rdy),
        .i_ret_valid (i_ret_valid),
        .i_ret_data  (i_ret_data),
        .d_rd_req    (d_rd_req),
        .d_rd_type   (d_rd_type),
        .d_rd_addr   (d_rd_addr),
        .d_rd_rdy    (d_rd_rdy),
        .d_ret_valid (d_ret_valid),
        .d_ret_data  (d_ret_data),
        .arid        (arid),
        .araddr      (araddr),
        .arlen       (arlen),
        .arsize      (arsize),
        .arburst     (arburst),
        .arvalid     (arvalid),
        .arready     (arready),
        .rdata       (rdata),
        .rlast       (rlast),
        .rvalid      (rvalid),
        .rready      (rready)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_arvalid"}, arvalid, 1'b0);
        chk({tag, "_rready"}, rready, 1'b0);
        chk({tag, "_i_rdy"}, i_rd_rdy, 1'b0);
        chk({tag, "_d_rdy"}, d_rd_rdy, 1'b0);
        chk({tag, "_i_ret"}, i_ret_valid, 1'b0);
        chk({tag, "_d_ret"}, d_ret_valid, 1'b0);
    endtask

    task automatic raise(input int who, input logic typ, input logic [31:0] addr);
        if (who == 0) begin
            i_rd_req = 1'b1; i_rd_type = typ; i_rd_addr = addr;
        end else begin
            d_rd_req = 1'b1; d_rd_type = typ; d_rd_addr = addr;
        end
    endtask

    task automatic raise_rand(input int who);
        logic typ;
        logic [31:0] a;
        typ = 1'($urandom_range(0, 1));
        a = $urandom;
        a = typ ? (a & 32'hFFFF_FFE0) : (a & 32'hFFFF_FFFC);
        raise(who, typ, a);
    endtask

    // Called at a negedge with reset high for a few cycles; requests are
    // held high during reset to show that no rd_rdy leaks out.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        i_rd_req = 1'b1; d_rd_req = 1'b1;
        #1;
        chk_quiet("in_reset");
        @(negedge clk);
        i_rd_req = 1'b0; d_rd_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_last = 0;
        #1;
        chk_quiet("after_reset");
    endtask

    // Entered at a negedge with requests already driven; leaves at a negedge.
    // nb < 0 picks a random beat count; gap < 0 picks random R-beat gaps;
    // seed != 0 makes beat k equal seed*(k+1).
    task automatic serve(input int nb_in, input int ar_delay, input int gap,
                         input logic [31:0] seed, input bit reset_mid);
        int w;
        int nb;
        int g;
        int r;
        logic exp_type;
        logic [31:0] exp_addr;
        logic [31:0] v;
        logic [255:0] exp_line;
        #1;
        if (i_rd_req && d_rd_req) w = (model_last == 0) ? 1 : 0;
        else if (d_rd_req)        w = 1;
        else if (i_rd_req)        w = 0;
        else                      w = -1;
        chk("i_rd_rdy", i_rd_rdy, w == 0);
        chk("d_rd_rdy", d_rd_rdy, w == 1);
        if (w < 0) return;
        model_last = w;
        exp_type = (w == 1) ? d_rd_type : i_rd_type;
        exp_addr = (w == 1) ? d_rd_addr : i_rd_addr;
        nb = nb_in;
        if (nb < 0) begin
            r = $urandom_range(0, 9);
            if (!exp_type)  nb = 1;
            else if (r < 6) nb = 8;
            else if (r < 8) nb = $urandom_range(1, 7);
            else            nb = 9;
        end
        txn_no++;
        $display("txn %0d: owner=%s type=%s addr=%h beats=%0d ar_delay=%0d%s",
                 txn_no, (w == 1) ? "D" : "I", exp_type ? "line" : "uncached",
                 exp_addr, nb, ar_delay, reset_mid ? " reset_mid" : "");

        // AR phase
        @(negedge clk);
        if (w == 1) d_rd_req = 1'b0; else i_rd_req = 1'b0;
        for (int k = 0; k <= ar_delay; k++) begin
            if (k > 0) @(negedge clk);
            arready = (k == ar_delay);
            #1;
            chk("arvalid", arvalid, 1'b1);
            chk("araddr", araddr, exp_addr);
            chk("arid", arid, (w == 1) ? 4'd1 : 4'd0);
            chk("arlen", arlen, exp_type ? 8'd7 : 8'd0);
            chk("arsize", arsize, 3'b010);
            chk("arburst", arburst, 2'b01);
            if (k == 0) begin
                chk("ar_rready", rready, 1'b0);
                chk("ar_i_rdy", i_rd_rdy, 1'b0);
                chk("ar_d_rdy", d_rd_rdy, 1'b0);
            end
        end
        @(negedge clk);
        arready = 1'b0;

        // R phase
        exp_line = '0;
        for (int b = 0; b < nb; b++) begin
            rvalid = 1'b0;
            rlast = 1'b0;
            g = (gap >= 0) ? gap : $urandom_range(0, 2);
            repeat (g) @(negedge clk);
            v = (seed != 0) ? seed * 32'(b + 1) : $urandom;
            rdata = v;
            rlast = (b == nb - 1);
            rvalid = 1'b1;
            if (b < 8) exp_line[32*b +: 32] = v;
            #1;
            chk("rready", rready, 1'b1);
            chk("r_arvalid", arvalid, 1'b0);
            @(negedge clk);
            if (reset_mid && b == 3) begin
                rvalid = 1'b0; rlast = 1'b0; reset = 1'b1;
                #1;
                chk_quiet("mid_reset");
                @(negedge clk);
                reset = 1'b0;
                model_last = 0;
                #1;
                chk_quiet("post_mid_reset");
                return;
            end
        end
        rvalid = 1'b0;
        rlast = 1'b0;
        #1;

        // RESP: one cycle after the rlast handshake
        chk("ret_valid_owner", (w == 1) ? d_ret_valid : i_ret_valid, 1'b1);
        chk("ret_valid_other", (w == 1) ? i_ret_valid : d_ret_valid, 1'b0);
        chk("ret_data", (w == 1) ? d_ret_data : i_ret_data, exp_line);
        @(negedge clk);
        chk("ret_pulse_i", i_ret_valid, 1'b0);
        chk("ret_pulse_d", d_ret_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        i_rd_req = 1'b0; i_rd_type = 1'b0; i_rd_addr = '0;
        d_rd_req = 1'b0; d_rd_type = 1'b0; d_rd_addr = '0;
        arready = 1'b0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // icache line refill with a known beat pattern
        raise(0, 1'b1, 32'h1FC0_0020);
        serve(8, 0, 0, 32'h11, 1'b0);

        // dcache uncached single word
        raise(1, 1'b0, 32'hBFAF_8000);
        serve(1, 0, 0, 32'hDEAD_BEEF, 1'b0);

        // ties after reset: D, then I, then D, then the held I
        do_reset();
        raise(0, 1'b1, 32'h0000_1000);
        raise(1, 1'b1, 32'h0000_2000);
        serve(8, 1, 0, 32'h0, 1'b0);
        raise(1, 1'b0, 32'h0000_2004);
        serve(-1, 0, 0, 32'h0, 1'b0);
        raise(0, 1'b1, 32'h0000_3000);
        serve(-1, 0, 0, 32'h0, 1'b0);
        serve(-1, 0, 0, 32'h0, 1'b0);

        // slow AR handshake and gapped R beats
        raise(0, 1'b1, 32'h8000_0040);
        serve(8, 5, 1, 32'h0, 1'b0);

        // reset in the middle of the R phase, then a normal refill
        raise(0, 1'b1, 32'h8000_0080);
        serve(8, 0, 0, 32'h0, 1'b1);
        raise(0, 1'b1, 32'h8000_00A0);
        serve(8, 0, 0, 32'h0, 1'b0);

        // early rlast on beat 4
        raise(1, 1'b1, 32'h4000_0100);
        serve(4, 0, 0, 32'h0, 1'b0);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            if (!i_rd_req && ($urandom_range(0, 1) == 1)) raise_rand(0);
            if (!d_rd_req && ($urandom_range(0, 1) == 1)) raise_rand(1);
            if (!i_rd_req && !d_rd_req) raise_rand($urandom_range(0, 1));
            serve(-1, $urandom_range(0, 3), -1, 32'h0, 1'b0);
        end
        // drain whichever request is still held
        serve(-1, 0, -1, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
